// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: byte-wide config register file behind the I2C slave.
// Holds the control, sticky IRQ, trigger period (shadowed commit) and timestamp snapshot registers.
module i2c_reg_bank #(
  parameter logic [7:0]  DEVICE_ID    = 8'hC5,
  parameter logic [7:0]  VERSION      = 8'h01,
  parameter logic [31:0] PERIOD_RESET = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  output logic [7:0]  reg_rdata,
  input  logic [7:0]  status_in,
  input  logic [7:0]  event_in,
  input  logic [31:0] ts_count,
  output logic        ctrl_enable,
  output logic [1:0]  ctrl_mode,
  output logic [31:0] trig_period,
  output logic        trig_period_upd,
  output logic [31:0] ts_snapshot,
  output logic        irq
);
  logic [7:0]  r_rdata;
  logic        r_ctrl_enable;
  logic [1:0]  r_ctrl_mode;
  logic [7:0]  r_irq_stat;
  logic [7:0]  r_irq_mask;
  logic [7:0]  r_scratch;
  logic [23:0] r_shadow;
  logic [31:0] r_trig_period;
  logic        r_trig_period_upd;
  logic [31:0] r_ts_snapshot;
  logic        r_irq;
  logic [7:0]  w_rdata;
  logic [15:0] w_we;
  logic [7:0]  w_clr;
  logic        w_unused;
  assign w_unused = reg_rd_en;
  // one-hot write enable over the 16 low addresses; anything above 0x0F decodes to nothing
  assign w_we  = (reg_wr_en && reg_addr[7:4] == 4'h0) ? (16'd1 << reg_addr[3:0]) : 16'd0;
  assign w_clr = w_we[4] ? reg_wdata : 8'h00;
  always_comb begin
    w_rdata = 8'h00;
    case (reg_addr)
      8'h00: w_rdata = DEVICE_ID;
      8'h01: w_rdata = VERSION;
      8'h02: w_rdata = {4'h0, r_ctrl_mode, 1'b0, r_ctrl_enable};
      8'h03: w_rdata = status_in;
      8'h04: w_rdata = r_irq_stat;
      8'h05: w_rdata = r_irq_mask;
      8'h06: w_rdata = r_trig_period[7:0];
      8'h07: w_rdata = r_trig_period[15:8];
      8'h08: w_rdata = r_trig_period[23:16];
      8'h09: w_rdata = r_trig_period[31:24];
      8'h0A: w_rdata = r_ts_snapshot[7:0];
      8'h0B: w_rdata = r_ts_snapshot[15:8];
      8'h0C: w_rdata = r_ts_snapshot[23:16];
      8'h0D: w_rdata = r_ts_snapshot[31:24];
      8'h0E: w_rdata = r_scratch;
      default: w_rdata = 8'h00;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata           <= 8'h00;
      r_ctrl_enable     <= 1'b0;
      r_ctrl_mode       <= 2'b00;
      r_irq_stat        <= 8'h00;
      r_irq_mask        <= 8'h00;
      r_scratch         <= 8'h00;
      r_shadow          <= 24'h0;
      r_trig_period     <= PERIOD_RESET;
      r_trig_period_upd <= 1'b0;
      r_ts_snapshot     <= 32'h0;
      r_irq             <= 1'b0;
    end else begin
      r_rdata           <= w_rdata;
      r_trig_period_upd <= w_we[9];
      r_irq_stat        <= (r_irq_stat & ~w_clr) | event_in;
      r_irq             <= |(r_irq_stat & r_irq_mask);
      if (w_we[2]) begin
        r_ctrl_enable <= reg_wdata[0];
        r_ctrl_mode   <= reg_wdata[3:2];
        if (reg_wdata[1]) r_ts_snapshot <= ts_count;
      end
      if (w_we[5]) r_irq_mask <= reg_wdata;
      if (w_we[6]) r_shadow[7:0] <= reg_wdata;
      if (w_we[7]) r_shadow[15:8] <= reg_wdata;
      if (w_we[8]) r_shadow[23:16] <= reg_wdata;
      if (w_we[9]) r_trig_period <= {reg_wdata, r_shadow};
      if (w_we[14]) r_scratch <= reg_wdata;
    end
  end
  assign reg_rdata       = r_rdata;
  assign ctrl_enable     = r_ctrl_enable;
  assign ctrl_mode       = r_ctrl_mode;
  assign trig_period     = r_trig_period;
  assign trig_period_upd = r_trig_period_upd;
  assign ts_snapshot     = r_ts_snapshot;
  assign irq             = r_irq;
endmodule
